json_token_scanner: RTL and testbench

Streaming hardware front end for the JSON decoder. Consumes raw document bytes over a valid/ready stream and emits a token stream (structural chars, string spans, scalar spans, end-of-document) for the downstream value builder. Detects lexical and bracket-balance errors and reports an error kind plus the 0-based byte index (json_idx) in the same form the decoder's error checkers compare against.

---
 rtl/json_token_scanner.sv | 235 +++++++++++++++++++++++
 tb/tb_json_token_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/json_token_scanner.sv
`default_nettype none
// ============================================================================
// json_token_scanner : streaming JSON lexer, bytes in -> token stream out
// Revision 1.0
// ============================================================================
module json_token_scanner #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_kind,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_len,
    output logic             err_valid,
    output logic [2:0]       err_kind,
    output logic [IDX_W-1:0] err_idx
);
    localparam int            DW        = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [3:0] K_OBJ_BEGIN = 4'd0, K_OBJ_END = 4'd1, K_ARR_BEGIN = 4'd2;
    localparam logic [3:0] K_ARR_END   = 4'd3, K_COLON   = 4'd4, K_COMMA     = 4'd5;
    localparam logic [3:0] K_STRING    = 4'd6, K_SCALAR  = 4'd7, K_EOF       = 4'd8;

    localparam logic [2:0] E_NONE       = 3'd0, E_UNBALANCED   = 3'd1, E_DEPTH    = 3'd2;
    localparam logic [2:0] E_EOF_STRING = 3'd3, E_EOF_UNCLOSED = 3'd4, E_BAD_ESC  = 3'd5;
    localparam logic [2:0] E_CTRL       = 3'd6;

    typedef enum logic [2:0] {
        SCAN   = 3'd0,
        STRING = 3'd1,
        ESCAPE = 3'd2,
        SCALAR = 3'd3,
        FINISH = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n, tok_idx, tok_idx_n, tok_len, tok_len_n, last_idx, last_idx_n;
    logic [DW-1:0]    depth, depth_n;
    logic [DEPTH-1:0] stack, stack_n;
    logic             scal_pend, scal_pend_n;
    logic             out_valid_n, err_valid_n;
    logic [3:0]       out_kind_n;
    logic [IDX_W-1:0] out_idx_n, out_len_n, err_idx_n;
    logic [2:0]       err_kind_n, err, eof_err, err_f;
    logic             is_ws, is_struct, is_term, esc_ok, slot_free, accept, close_arr;

    assign is_ws     = in_data inside {8'h20, 8'h09, 8'h0A, 8'h0D};
    assign is_struct = in_data inside {8'h7B, 8'h7D, 8'h5B, 8'h5D, 8'h3A, 8'h2C};
    assign is_term   = is_ws || is_struct || (in_data == 8'h22);
    assign esc_ok    = in_data inside {8'h22, 8'h5C, 8'h2F, 8'h62, 8'h66, 8'h6E, 8'h72, 8'h74, 8'h75};
    assign close_arr = (in_data == 8'h5D);
    assign slot_free = !out_valid || out_ready;

    // A scalar terminator is held back so SCAN can re-examine it next cycle
    assign in_ready = !rst && !err_valid && slot_free &&
                      ((state == SCAN) || (state == STRING) || (state == ESCAPE) ||
                       ((state == SCALAR) && !is_term));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        depth_n     = depth;
        stack_n     = stack;
        tok_idx_n   = tok_idx;
        tok_len_n   = tok_len;
        last_idx_n  = last_idx;
        scal_pend_n = scal_pend;
        out_valid_n = out_valid && !out_ready;
        out_kind_n  = out_kind;
        out_idx_n   = out_idx;
        out_len_n   = out_len;
        err_valid_n = err_valid;
        err_kind_n  = err_kind;
        err_idx_n   = err_idx;
        err         = E_NONE;
        eof_err     = E_NONE;
        err_f       = E_NONE;

        case (state)
            SCAN: if (accept) begin
                idx_n     = idx + IDX_W'(1);
                out_idx_n = idx;
                out_len_n = '0;
                if (in_data == 8'h7B || in_data == 8'h5B) begin
                    if (depth == DEPTH_MAX) err = E_DEPTH;
                    else begin
                        stack_n     = {stack[DEPTH-2:0], in_data == 8'h5B};
                        depth_n     = depth + DW'(1);
                        out_valid_n = 1'b1;
                        out_kind_n  = (in_data == 8'h7B) ? K_OBJ_BEGIN : K_ARR_BEGIN;
                    end
                end else if (in_data == 8'h7D || close_arr) begin
                    if (depth == '0 || stack[0] != close_arr) err = E_UNBALANCED;
                    else begin
                        stack_n     = {1'b0, stack[DEPTH-1:1]};
                        depth_n     = depth - DW'(1);
                        out_valid_n = 1'b1;
                        out_kind_n  = close_arr ? K_ARR_END : K_OBJ_END;
                    end
                end else if (in_data == 8'h3A || in_data == 8'h2C) begin
                    out_valid_n = 1'b1;
                    out_kind_n  = (in_data == 8'h3A) ? K_COLON : K_COMMA;
                end else if (in_data == 8'h22) begin
                    state_n   = STRING;
                    tok_idx_n = idx;
                    tok_len_n = '0;
                end else if (!is_ws) begin
                    state_n   = SCALAR;
                    tok_idx_n = idx;
                    tok_len_n = IDX_W'(1);
                end
            end
            SCALAR: begin
                if (in_valid && is_term && slot_free) begin
                    state_n     = SCAN;
                    out_valid_n = 1'b1;
                    out_kind_n  = K_SCALAR;
                    out_idx_n   = tok_idx;
                    out_len_n   = tok_len;
                end else if (accept) begin
                    idx_n     = idx + IDX_W'(1);
                    tok_len_n = tok_len + IDX_W'(1);
                end
            end
            STRING: if (accept) begin
                idx_n = idx + IDX_W'(1);
                if (in_data == 8'h22) begin
                    state_n     = SCAN;
                    out_valid_n = 1'b1;
                    out_kind_n  = K_STRING;
                    out_idx_n   = tok_idx;
                    out_len_n   = tok_len;
                end else begin
                    tok_len_n = tok_len + IDX_W'(1);
                    if (in_data == 8'h5C) state_n = ESCAPE;
                    else if (in_data < 8'h20) err = E_CTRL;
                end
            end
            ESCAPE: if (accept) begin
                idx_n     = idx + IDX_W'(1);
                tok_len_n = tok_len + IDX_W'(1);
                state_n   = STRING;
                if (!esc_ok) err = E_BAD_ESC;
            end
            FINISH: if (slot_free) begin
                out_valid_n = 1'b1;
                if (scal_pend) begin
                    scal_pend_n = 1'b0;
                    out_kind_n  = K_SCALAR;
                    out_idx_n   = tok_idx;
                    out_len_n   = tok_len;
                end else begin
                    out_kind_n = K_EOF;
                    out_idx_n  = last_idx;
                    out_len_n  = '0;
                    state_n    = SCAN;
                    idx_n      = '0;
                    depth_n    = '0;
                    stack_n    = '0;
                end
            end
            default: ;
        endcase

        // End-of-document checks look at where this byte left the lexer
        if (accept && in_last) begin
            last_idx_n = idx;
            if (state_n == STRING || state_n == ESCAPE) eof_err = E_EOF_STRING;
            else if (depth_n != '0)                     eof_err = E_EOF_UNCLOSED;
        end
        err_f = err;
        if (eof_err != E_NONE && (err == E_NONE || eof_err < err)) err_f = eof_err;

        if (err_f != E_NONE) begin
            state_n     = ERROR;
            out_valid_n = out_valid && !out_ready;
            out_kind_n  = out_kind;
            out_idx_n   = out_idx;
            out_len_n   = out_len;
            err_valid_n = 1'b1;
            err_kind_n  = err_f;
            err_idx_n   = idx;
        end else if (accept && in_last) begin
            scal_pend_n = (state_n == SCALAR);
            state_n     = FINISH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            idx       <= '0;
            depth     <= '0;
            stack     <= '0;
            tok_idx   <= '0;
            tok_len   <= '0;
            last_idx  <= '0;
            scal_pend <= 1'b0;
            out_valid <= 1'b0;
            out_kind  <= '0;
            out_idx   <= '0;
            out_len   <= '0;
            err_valid <= 1'b0;
            err_kind  <= '0;
            err_idx   <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            depth     <= depth_n;
            stack     <= stack_n;
            tok_idx   <= tok_idx_n;
            tok_len   <= tok_len_n;
            last_idx  <= last_idx_n;
            scal_pend <= scal_pend_n;
            out_valid <= out_valid_n;
            out_kind  <= out_kind_n;
            out_idx   <= out_idx_n;
            out_len   <= out_len_n;
            err_valid <= err_valid_n;
            err_kind  <= err_kind_n;
            err_idx   <= err_idx_n;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_json_token_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_json_token_scanner : directed self-checking bench for json_token_scanner
// Revision 1.0
// ============================================================================
module tb_json_token_scanner;
    localparam int IDX_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_kind;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W-1:0] out_len;
    logic             err_valid;
    logic [2:0]       err_kind;
    logic [IDX_W-1:0] err_idx;

    int          vectors     = 0;
    int          miscompares = 0;
    logic        toggle_ready = 1'b0;
    logic [35:0] toks[$];

    json_token_scanner #(.DEPTH(4), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_idx(out_idx), .out_len(out_len),
        .err_valid(err_valid), .err_kind(err_kind), .err_idx(err_idx)
    );

    initial forever #5 clk = ~clk;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = toggle_ready ? !out_ready : 1'b1;
        end
    end

    // Token handshakes are recorded at the negedge preceding the accepting edge
    initial forever begin
        @(negedge clk);
        if (out_valid && out_ready && !rst) toks.push_back({out_kind, out_idx, out_len});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("handshake", {63'd0, ok}, 64'd1);
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
    endtask

    task automatic expect_tok(input string tag, input int k, input int i, input int l);
        int          n;
        logic [35:0] obs;
        n = 0;
        while (toks.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
        obs = (toks.size() != 0) ? toks.pop_front() : 36'hF_FFFF_FFFF;
        chk(tag, {28'd0, obs}, {28'd0, k[3:0], i[15:0], l[15:0]});
    endtask

    task automatic expect_quiet(input string tag);
        int sz;
        repeat (10) begin @(posedge clk); #1; end
        sz = toks.size();
        chk(tag, 64'(sz), 64'd0);
    endtask

    task automatic expect_err(input string tag, input int k, input int i);
        repeat (3) begin @(posedge clk); #1; end
        chk(tag, {44'd0, err_valid, err_kind, err_idx}, {44'd0, 1'b1, k[2:0], i[15:0]});
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        chk("reset state",
            {6'd0, out_valid, out_kind, out_idx, out_len, err_valid, err_kind, err_idx, in_ready},
            64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        toks.delete();
    endtask

    int   doc1 [10][3] = '{'{0,0,0}, '{6,1,1}, '{4,4,0}, '{2,5,0}, '{7,6,1},
                           '{5,7,0}, '{7,8,1}, '{3,9,0}, '{1,10,0}, '{8,10,0}};
    logic stuck;

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Nested document with strings, scalars and separators
        send_str("{\"a\":[1,2]}", 1'b1);
        for (int j = 0; j < 10; j++) expect_tok("doc1 token", doc1[j][0], doc1[j][1], doc1[j][2]);
        chk("doc1 no error", {63'd0, err_valid}, 64'd0);

        // Scalar closed by end of document, then again under backpressure
        send_str("true", 1'b1);
        expect_tok("true scalar", 7, 0, 4);
        expect_tok("true eof", 8, 3, 0);
        toggle_ready = 1'b1;
        send_str("true", 1'b1);
        expect_tok("true bp scalar", 7, 0, 4);
        expect_tok("true bp eof", 8, 3, 0);
        expect_quiet("true bp no duplicate");
        toggle_ready = 1'b0;

        // Whitespace-only document
        send_str(" \t", 1'b1);
        expect_tok("ws eof", 8, 1, 0);
        expect_quiet("ws no extra");

        // Mismatched close bracket
        send_str("[1}", 1'b0);
        expect_tok("unbal arr", 2, 0, 0);
        expect_tok("unbal scalar", 7, 1, 1);
        expect_err("unbalanced", 1, 2);
        stuck = 1'b0;
        in_valid = 1'b1; in_data = 8'h2C;
        repeat (5) begin @(negedge clk); stuck = stuck | in_ready; @(posedge clk); #1; end
        in_valid = 1'b0;
        chk("in_ready low in error", {63'd0, stuck}, 64'd0);
        expect_quiet("no token after error");
        do_reset();

        // End of document inside a string
        send_str("\"ab", 1'b1);
        expect_err("eof in string", 3, 2);
        do_reset();

        // Illegal escape
        send_str("\"\\q", 1'b0);
        expect_err("bad escape", 5, 2);
        do_reset();

        // Nesting beyond DEPTH=4
        send_str("[[[[[", 1'b0);
        for (int j = 0; j < 4; j++) expect_tok("depth arr", 2, j, 0);
        expect_err("depth exceeded", 2, 4);
        do_reset();

        // Reset mid-document, then a fresh document restarts at index 0
        send_str("{\"x", 1'b0);
        do_reset();
        send_str("[]", 1'b1);
        expect_tok("post-reset arr begin", 2, 0, 0);
        expect_tok("post-reset arr end", 3, 1, 0);
        expect_tok("post-reset eof", 8, 1, 0);
        chk("post-reset no error", {63'd0, err_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
